voice_alloc: RTL
================

# voice_alloc

Polyphonic voice allocator sitting between the note-event source (keyboard/MIDI decoder) and a bank of NVOICES `adsr` instances. It accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a voice. It drives each voice's `trig` (gate) and note number, using LRU ranking and voice stealing when all voices are busy. Each `adsr` envelope reports back whether it is silent, so released voices are reused only after their release tail ends where possible.

## Interface
- NVOICES, 4: number of voices (power of two, 2..8)
- NOTEW, 7: note number width
- RETRIG_CYCLES, 4: clk cycles the gate is forced low when stealing/retriggering (≥ one `ce` period of `adsr`)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- evt_valid  in  1  event present
- evt_ready  out  1  allocator can accept an event
- evt_on  in  1  1 = note-on, 0 = note-off
- evt_note  in  NOTEW  note number of event
- env_idle  in  NVOICES  per voice, 1 when that `adsr` envelope == 0
- gate  out  NVOICES  per-voice `trig` to `adsr`
- voice_note  out  NVOICES*NOTEW  note of voice v at bits [v*NOTEW +: NOTEW]
- alloc_pulse  out  1  one-cycle pulse when a note-on is assigned
- alloc_voice  out  $clog2(NVOICES)  voice index of last assignment

## Operation
- States: IDLE, RETRIG. `evt_ready` = (state == IDLE) && !rst; an event is accepted on clk edge with evt_valid && evt_ready.
- Per voice: gate bit, note register, LRU rank (0 = most recent, NVOICES-1 = oldest); ranks always a permutation of 0..NVOICES-1.
- Note-off accepted: every voice with gate=1 and note == evt_note gets gate=0 next cycle; notes/ranks unchanged; no alloc_pulse; stay IDLE. A note-off matching no voice is ignored.
- Note-on accepted, selection priority (first match wins):
  1. Gated voice already holding evt_note -> retrigger that voice (RETRIG).
  2. Free voice (gate=0 && env_idle=1) -> lowest index wins; gate=1 next cycle; stay IDLE.
  3. Released voice (gate=0 && env_idle=0) -> highest rank wins; gate=1 next cycle; stay IDLE.
  4. All gated -> steal highest-rank voice (RETRIG).
- RETRIG: chosen voice's gate=0 for exactly RETRIG_CYCLES cycles, then gate=1 and state returns to IDLE. evt_ready=0 throughout.
- On every note-on assignment, with the same timing for all four cases:
  - note register <= evt_note.
  - Chosen voice rank <= 0.
  - Voices with rank < old rank of chosen voice increment.
  - alloc_voice <= index.
  - alloc_pulse=1 for one cycle.
- Other voices' gates/notes are never disturbed by a note-on.

## Timing
- Reset values:
  - gate=0, all voice_note=0.
  - rank[v]=v, so voice NVOICES-1 is oldest.
  - alloc_pulse=0, alloc_voice=0.
  - state=IDLE; evt_ready=0 while rst is high.
- Accept at edge k:
  - Note-off: gate change visible at k+1.
  - Note-on cases 2/3: gate, voice_note and alloc_pulse visible at k+1; next event acceptable at k+1.
  - Note-on cases 1/4: voice_note and alloc_pulse visible at k+1; gate low during cycles k+1..k+RETRIG_CYCLES; gate high at k+RETRIG_CYCLES+1, which is the same cycle evt_ready returns to 1.
- Case 3 on a releasing voice produces a gate 0->1 edge at k+1 with no forced low period.
- env_idle is sampled only in the accept cycle; no registering or combinational path to evt_ready.
- Reset mid-RETRIG: all state returns to reset values next edge; the pending retrigger is discarded.
- Back-to-back events with evt_valid held high: one accepted per IDLE cycle.

## Test plan
- Reset, env_idle=4'b1111, note-on 60, 62, 64, 67 back-to-back -> voices 0,1,2,3 gated at one event per cycle; alloc_voice 0,1,2,3; ranks end [3,2,1,0].
- Then note-off 62 -> gate=4'b1101 one cycle after accept; voice_note unchanged. Set env_idle[1]=0 and issue note-on 70 -> voice 1 (released) re-gated at k+1 with note 70.
- All four gated, note-on 72 -> voice 0 (oldest) stolen:
  - gate[0] low for 4 cycles then high, voice_note[0]=72.
  - evt_ready low for 4 cycles.
  - Other gates stay 1.
- Note-on 64 while voice 2 gated on 64 -> voice 2 retriggered (4-cycle low pulse); no other voice changes; rank[2]=0.
- Two voices released, env_idle=4'b0101 for them (voice 0 idle, voice 1 not idle) -> note-on picks voice 0 (free) over voice 1 (released).
- rst asserted at cycle 2 of RETRIG -> next cycle gate=0, ranks [0,1,2,3]; evt_ready=1 after rst drops.

Source files
------------

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note events onto a bank of adsr voices
// using LRU ranking, release-aware reuse and voice stealing.
module voice_alloc #(
  parameter int NVOICES       = 4,
  parameter int NOTEW         = 7,
  parameter int RETRIG_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       evt_valid,
  output logic                       evt_ready,
  input  logic                       evt_on,
  input  logic [NOTEW-1:0]           evt_note,
  input  logic [NVOICES-1:0]         env_idle,
  output logic [NVOICES-1:0]         gate,
  output logic [NVOICES*NOTEW-1:0]   voice_note,
  output logic                       alloc_pulse,
  output logic [$clog2(NVOICES)-1:0] alloc_voice
);

  localparam int VW = $clog2(NVOICES);
  localparam int CW = $clog2(RETRIG_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RETRIG
  } state_t;

  state_t           state;
  logic [NOTEW-1:0] note [NVOICES];
  logic [VW-1:0]    rank [NVOICES];
  logic [CW-1:0]    cnt;
  logic [VW-1:0]    rvoice;

  logic          accept;
  logic          hit, free, rel, retrig;
  logic [VW-1:0] hit_v, free_v, rel_v, old_v, sel;
  logic [VW-1:0] rel_rank;

  assign evt_ready = (state == IDLE) && !rst;
  assign accept    = evt_valid && evt_ready;

  for (genvar v = 0; v < NVOICES; v++) begin : g_note
    assign voice_note[v*NOTEW +: NOTEW] = note[v];
  end

  always_comb begin
    hit      = 1'b0;
    hit_v    = '0;
    free     = 1'b0;
    free_v   = '0;
    rel      = 1'b0;
    rel_v    = '0;
    rel_rank = '0;
    old_v    = '0;
    // descending scan so the lowest index is left standing
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (gate[v] && note[v] == evt_note) begin
        hit   = 1'b1;
        hit_v = VW'(v);
      end
      if (!gate[v] && env_idle[v]) begin
        free   = 1'b1;
        free_v = VW'(v);
      end
    end
    for (int v = 0; v < NVOICES; v++) begin
      if (!gate[v] && !env_idle[v] &&
          (!rel || rank[v] > rel_rank)) begin
        rel      = 1'b1;
        rel_v    = VW'(v);
        rel_rank = rank[v];
      end
      if (rank[v] == VW'(NVOICES - 1)) begin
        old_v = VW'(v);
      end
    end
    if (hit) begin
      sel = hit_v;
    end else if (free) begin
      sel = free_v;
    end else if (rel) begin
      sel = rel_v;
    end else begin
      sel = old_v;
    end
    retrig = hit || (!free && !rel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gate        <= '0;
      alloc_pulse <= 1'b0;
      alloc_voice <= '0;
      cnt         <= '0;
      rvoice      <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        note[v] <= '0;
        rank[v] <= VW'(v);
      end
    end else begin
      alloc_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && evt_on) begin
            note[sel]   <= evt_note;
            alloc_voice <= sel;
            alloc_pulse <= 1'b1;
            for (int v = 0; v < NVOICES; v++) begin
              if (VW'(v) == sel) begin
                rank[v] <= '0;
              end else if (rank[v] < rank[sel]) begin
                rank[v] <= rank[v] + 1'b1;
              end
            end
            if (retrig) begin
              gate[sel] <= 1'b0;
              rvoice    <= sel;
              cnt       <= CW'(RETRIG_CYCLES - 1);
              state     <= RETRIG;
            end else begin
              gate[sel] <= 1'b1;
            end
          end else if (accept) begin
            for (int v = 0; v < NVOICES; v++) begin
              if (gate[v] && note[v] == evt_note) begin
                gate[v] <= 1'b0;
              end
            end
          end
        end
        RETRIG: begin
          if (cnt == '0) begin
            gate[rvoice] <= 1'b1;
            state        <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
